// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
// approx_mult_pkg : shared types/constants for approximate-multiplier metrics
// Revision: 1.0
// ============================================================================
package approx_mult_pkg;

  localparam int PROD_W = 16;
  localparam int OPND_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/err_dist_16.sv
`default_nettype none
// ============================================================================
// err_dist_16 : combinational |x - y| on 16-bit unsigned operands + nonzero flag
// Revision: 1.0
// ============================================================================
module err_dist_16
  import approx_mult_pkg::*;
(
  input  logic [PROD_W-1:0] i_x,
  input  logic [PROD_W-1:0] i_y,
  output logic [PROD_W-1:0] o_ed,
  output logic              o_nz
);

  // Subtract in the direction that cannot go negative, so the result never wraps.
  assign o_ed = (i_x >= i_y) ? (i_x - i_y) : (i_y - i_x);
  assign o_nz = (i_x != i_y);

endmodule
`default_nettype wire

// File: rtl/mult_8x8_err_acc.sv
`default_nettype none
// ============================================================================
// mult_8x8_err_acc : error-distance statistics for an 8x8 approximate multiplier
// Revision: 1.0
// ============================================================================
module mult_8x8_err_acc
  import approx_mult_pkg::*;
#(
  parameter int N_SAMPLES = 256,
  parameter int CNT_W     = 16,
  parameter int SUM_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [PROD_W-1:0] r_apx,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_ed,
  output logic [PROD_W-1:0] max_ed,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  smp_cnt
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_SAMPLES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_clear;
  logic                w_xfer;
  logic [PROD_W-1:0]   w_prod;
  logic [PROD_W-1:0]   w_ed;
  logic                w_nz;

  logic [PROD_W-1:0]   r_exact;
  logic [PROD_W-1:0]   r_apx_s1;
  logic                r_v1;
  logic [SUM_W-1:0]    r_sum;
  logic [PROD_W-1:0]   r_max;
  logic [CNT_W-1:0]    r_err;
  logic [CNT_W-1:0]    r_smp;

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && (r_smp == C_LAST)) begin
          w_state_nxt = DRAIN;
        end
      end
      // The final sample retires on the edge that leaves DRAIN.
      DRAIN: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_clear     = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_xfer = in_valid & in_ready;
  assign w_prod = PROD_W'(a) * PROD_W'(b);

  err_dist_16 u_err_dist (
    .i_x  (r_exact),
    .i_y  (r_apx_s1),
    .o_ed (w_ed),
    .o_nz (w_nz)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_exact  <= '0;
      r_apx_s1 <= '0;
      r_v1     <= 1'b0;
      r_sum    <= '0;
      r_max    <= '0;
      r_err    <= '0;
      r_smp    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_v1    <= w_xfer;
      if (w_xfer) begin
        r_exact  <= w_prod;
        r_apx_s1 <= r_apx;
        r_smp    <= r_smp + CNT_W'(1);
      end
      if (w_clear) begin
        r_sum <= '0;
        r_max <= '0;
        r_err <= '0;
        r_smp <= '0;
      end else if (r_v1) begin
        r_sum <= r_sum + SUM_W'(w_ed);
        r_err <= r_err + CNT_W'(w_nz);
        if (w_ed > r_max) begin
          r_max <= w_ed;
        end
      end
    end
  end

  assign sum_ed  = r_sum;
  assign max_ed  = r_max;
  assign err_cnt = r_err;
  assign smp_cnt = r_smp;

endmodule
`default_nettype wire

// File: tb/tb_mult_8x8_err_acc.sv
`default_nettype none
// ============================================================================
// tb_mult_8x8_err_acc : directed runs of four samples, scoreboard on done
// Revision: 1.0
// ============================================================================
module tb_mult_8x8_err_acc;

  localparam int N     = 4;
  localparam int CNT_W = 16;
  localparam int SUM_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        a;
  logic [7:0]        b;
  logic [15:0]       apx;
  logic              busy;
  logic              done;
  logic [SUM_W-1:0]  sum_ed;
  logic [15:0]       max_ed;
  logic [CNT_W-1:0]  err_cnt;
  logic [CNT_W-1:0]  smp_cnt;

  mult_8x8_err_acc #(.N_SAMPLES(N), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .r_apx    (apx),
    .busy     (busy),
    .done     (done),
    .sum_ed   (sum_ed),
    .max_ed   (max_ed),
    .err_cnt  (err_cnt),
    .smp_cnt  (smp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sum;
    logic [15:0] mx;
    logic [15:0] ec;
    logic [15:0] sc;
  } exp_t;

  exp_t        q[$];
  exp_t        m_e;
  logic        prev_done = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  va[24];
  logic [7:0]  vb[24];
  logic [15:0] vr[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tv(input int idx, input logic [7:0] ai, input logic [7:0] bi, input logic [15:0] ri);
    va[idx] = ai;
    vb[idx] = bi;
    vr[idx] = ri;
  endtask

  task automatic push_exp(input logic [31:0] s, input logic [15:0] m, input logic [15:0] e);
    exp_t x;
    x.sum = s;
    x.mx  = m;
    x.ec  = e;
    x.sc  = 16'(N);
    q.push_back(x);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    check("start_smp_clr", 32'(smp_cnt), 32'd0);
    check("start_sum_clr", sum_ed, 32'd0);
    check("start_max_clr", 32'(max_ed), 32'd0);
    check("start_err_clr", 32'(err_cnt), 32'd0);
  endtask

  task automatic send(input int idx);
    wait_ready();
    a = va[idx];
    b = vb[idx];
    apx = vr[idx];
    in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_b2b(input int base);
    do_start();
    for (int i = 0; i < N; i++) send(base + i);
    in_valid = 1'b0;
    check("drain_done_low", {31'd0, done}, 32'd0);
    check("drain_busy", {31'd0, busy}, 32'd1);
    check("drain_smp", 32'(smp_cnt), 32'(N));
    @(posedge clk); #1;
    check("done_after_drain", {31'd0, done}, 32'd1);
    check("done_busy_low", {31'd0, busy}, 32'd0);
  endtask

  // Scoreboard monitor: compares one expectation per run on the rising edge of done.
  always @(negedge clk) begin
    if (!rst && done && !prev_done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        m_e = q.pop_front();
        check("sum_ed", sum_ed, m_e.sum);
        check("max_ed", 32'(max_ed), 32'(m_e.mx));
        check("err_cnt", 32'(err_cnt), 32'(m_e.ec));
        check("smp_cnt", 32'(smp_cnt), 32'(m_e.sc));
      end
    end
    prev_done = done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // A: exact products
    tv(0, 8'd0, 8'd0, 16'd0);      tv(1, 8'd255, 8'd255, 16'd65025);
    tv(2, 8'd17, 8'd3, 16'd51);    tv(3, 8'd128, 8'd2, 16'd256);
    // B: both signs of difference, large error
    tv(4, 8'd255, 8'd255, 16'hFE00); tv(5, 8'd2, 8'd3, 16'd7);
    tv(6, 8'd255, 8'd255, 16'd0);    tv(7, 8'd1, 8'd1, 16'd1);
    // C: toggling valid
    tv(8, 8'd0, 8'd9, 16'd0);      tv(9, 8'd10, 8'd10, 16'd90);
    tv(10, 8'd200, 8'd3, 16'd700); tv(11, 8'd16, 8'd16, 16'd0);
    // D: aborted run
    tv(12, 8'd5, 8'd5, 16'd20);    tv(13, 8'd6, 8'd6, 16'd30);
    tv(14, 8'd0, 8'd0, 16'd0);     tv(15, 8'd0, 8'd0, 16'd0);
    // E
    tv(16, 8'd3, 8'd5, 16'd14);    tv(17, 8'd100, 8'd100, 16'd10000);
    tv(18, 8'd7, 8'd7, 16'd0);     tv(19, 8'd255, 8'd1, 16'd256);
    // F
    tv(20, 8'd12, 8'd12, 16'd150); tv(21, 8'd1, 8'd2, 16'd2);
    tv(22, 8'd9, 8'd9, 16'd81);    tv(23, 8'd50, 8'd50, 16'd2400);

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; a = '0; b = '0; apx = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", sum_ed, 32'd0);
    check("rst_smp", 32'(smp_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);

    push_exp(32'd0, 16'd0, 16'd0);
    run_b2b(0);
    push_exp(32'd65027, 16'd65025, 16'd3);
    run_b2b(4);

    // C: valid 1,0,1,0 with start pulses in RUN and DRAIN
    push_exp(32'd366, 16'd256, 16'd3);
    do_start();
    for (int i = 0; i < N; i++) begin
      a = va[8 + i]; b = vb[8 + i]; apx = vr[8 + i];
      in_valid = 1'b1;
      start = (i != 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      start = 1'b0;
      check("toggle_smp", 32'(smp_cnt), 32'(i + 1));
      if (i < N - 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("toggle_still_run", {31'd0, in_ready}, 32'd1);
      end
    end
    check("toggle_drain", {31'd0, done}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("toggle_done", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check("done_hold", {31'd0, done}, 32'd1);
    check("done_hold_sum", sum_ed, 32'd366);

    // D: abort mid-run
    do_start();
    send(12);
    send(13);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("abort_in_ready", {31'd0, in_ready}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", sum_ed, 32'd0);
    check("abort_max", 32'(max_ed), 32'd0);
    check("abort_err", 32'(err_cnt), 32'd0);
    check("abort_smp", 32'(smp_cnt), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle", {31'd0, in_ready}, 32'd0);

    push_exp(32'd51, 16'd49, 16'd3);
    run_b2b(16);
    push_exp(32'd106, 16'd100, 16'd2);
    run_b2b(20);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
